// File: rtl/dac_sweep_ctrl.sv
// Triangle-sweep sequencer for one DAC channel with manual-write arbitration.
// Optional sweep sync pulse on trig_o is enabled by defining DAC_SWEEP_TRIG_EN.
module dac_sweep_ctrl #(
  parameter int DAC_DATA_WIDTH = 14,
  parameter int DIV_WIDTH      = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic [DAC_DATA_WIDTH-1:0] cfg_min_i,
  input  logic [DAC_DATA_WIDTH-1:0] cfg_max_i,
  input  logic [DAC_DATA_WIDTH-1:0] cfg_step_i,
  input  logic [DIV_WIDTH-1:0]      cfg_div_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      man_valid_i,
  input  logic [DAC_DATA_WIDTH-1:0] man_data_i,
  output logic                      man_ready_o,
  output logic [DAC_DATA_WIDTH-1:0] dac_data_o,
  output logic                      dac_tvalid_o,
  output logic                      busy_o,
  output logic                      dir_o,
  output logic                      cfg_err_o,
  output logic [CNT_WIDTH-1:0]      period_cnt_o,
  output logic                      trig_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  localparam logic [DAC_DATA_WIDTH-1:0] MID_CODE =
    DAC_DATA_WIDTH'(1) << (DAC_DATA_WIDTH - 1);

  state_t                      r_state, w_state_n;
  logic [DAC_DATA_WIDTH-1:0]   r_data, w_data_n;
  logic                        r_tvalid, w_tvalid_n;
  logic                        r_err, w_err_n;
  logic [CNT_WIDTH-1:0]        r_cnt, w_cnt_n;
  logic [DIV_WIDTH-1:0]        r_div, w_div_n;
  logic [DAC_DATA_WIDTH-1:0]   r_min, w_min_n;
  logic [DAC_DATA_WIDTH-1:0]   r_max, w_max_n;
  logic [DAC_DATA_WIDTH-1:0]   r_step, w_step_n;
  logic [DIV_WIDTH-1:0]        r_divcfg, w_divcfg_n;

  logic                        w_man_ready;
  logic                        w_cfg_ok;
  logic                        w_tick;
  logic [DAC_DATA_WIDTH:0]     w_sum;
  logic [DAC_DATA_WIDTH:0]     w_floor;

`ifdef DAC_SWEEP_TRIG_EN
  logic                        r_trig, w_trig_n;
`endif

  assign w_man_ready = (r_state == S_IDLE) && !start_i;
  assign w_cfg_ok    = (cfg_min_i < cfg_max_i) && (cfg_step_i != '0);
  assign w_tick      = (r_div == r_divcfg);
  // One extra bit so neither the up-ramp sum nor the down-ramp floor can wrap.
  assign w_sum       = {1'b0, r_data} + {1'b0, r_step};
  assign w_floor     = {1'b0, r_min} + {1'b0, r_step};

  always_comb begin
    w_state_n  = r_state;
    w_data_n   = r_data;
    w_tvalid_n = 1'b0;
    w_err_n    = r_err;
    w_cnt_n    = r_cnt;
    w_div_n    = r_div;
    w_min_n    = r_min;
    w_max_n    = r_max;
    w_step_n   = r_step;
    w_divcfg_n = r_divcfg;
`ifdef DAC_SWEEP_TRIG_EN
    w_trig_n   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          if (w_cfg_ok) begin
            w_min_n    = cfg_min_i;
            w_max_n    = cfg_max_i;
            w_step_n   = cfg_step_i;
            w_divcfg_n = cfg_div_i;
            w_err_n    = 1'b0;
            w_cnt_n    = '0;
            w_div_n    = '0;
            w_data_n   = cfg_min_i;
            w_tvalid_n = 1'b1;
            w_state_n  = S_UP;
`ifdef DAC_SWEEP_TRIG_EN
            w_trig_n   = 1'b1;
`endif
          end else begin
            w_err_n = 1'b1;
          end
        end else if (man_valid_i && w_man_ready) begin
          w_data_n   = man_data_i;
          w_tvalid_n = 1'b1;
        end
      end
      S_UP, S_DOWN: begin
        if (stop_i) begin
          w_state_n = S_IDLE;
          w_div_n   = '0;
        end else if (w_tick) begin
          w_div_n    = '0;
          w_tvalid_n = 1'b1;
          if (r_state == S_UP) begin
            if (w_sum >= {1'b0, r_max}) begin
              w_data_n  = r_max;
              w_state_n = S_DOWN;
            end else begin
              w_data_n = w_sum[DAC_DATA_WIDTH-1:0];
            end
          end else begin
            if ({1'b0, r_data} < w_floor) begin
              w_data_n  = r_min;
              w_state_n = S_UP;
              w_cnt_n   = r_cnt + CNT_WIDTH'(1);
`ifdef DAC_SWEEP_TRIG_EN
              w_trig_n  = 1'b1;
`endif
            end else begin
              w_data_n = r_data - r_step;
            end
          end
        end else begin
          w_div_n = r_div + DIV_WIDTH'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_data   <= MID_CODE;
      r_tvalid <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_div    <= '0;
      r_min    <= '0;
      r_max    <= '0;
      r_step   <= '0;
      r_divcfg <= '0;
    end else begin
      r_state  <= w_state_n;
      r_data   <= w_data_n;
      r_tvalid <= w_tvalid_n;
      r_err    <= w_err_n;
      r_cnt    <= w_cnt_n;
      r_div    <= w_div_n;
      r_min    <= w_min_n;
      r_max    <= w_max_n;
      r_step   <= w_step_n;
      r_divcfg <= w_divcfg_n;
    end
  end

`ifdef DAC_SWEEP_TRIG_EN
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_trig <= 1'b0;
    end else begin
      r_trig <= w_trig_n;
    end
  end
  assign trig_o = r_trig;
`else
  assign trig_o = 1'b0;
`endif

  assign man_ready_o  = w_man_ready;
  assign dac_data_o   = r_data;
  assign dac_tvalid_o = r_tvalid;
  assign busy_o       = (r_state != S_IDLE);
  assign dir_o        = (r_state == S_UP);
  assign cfg_err_o    = r_err;
  assign period_cnt_o = r_cnt;

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Self-checking bench for dac_sweep_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a sequence-table model of the triangle sweep.
module tb_dac_sweep_ctrl;
  localparam int DW = 14;
  localparam int VW = 16;
  localparam int CW = 16;
`ifdef DAC_SWEEP_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] cfg_min_i = '0, cfg_max_i = '0, cfg_step_i = '0;
  logic [VW-1:0] cfg_div_i = '0;
  logic          start_i = 1'b0, stop_i = 1'b0, man_valid_i = 1'b0;
  logic [DW-1:0] man_data_i = '0;
  logic          man_ready_o, dac_tvalid_o, busy_o, dir_o, cfg_err_o, trig_o;
  logic [DW-1:0] dac_data_o;
  logic [CW-1:0] period_cnt_o;

  always #5 clk = ~clk;

  dac_sweep_ctrl #(.DAC_DATA_WIDTH(DW), .DIV_WIDTH(VW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_i(rst_i), .cfg_min_i(cfg_min_i), .cfg_max_i(cfg_max_i),
    .cfg_step_i(cfg_step_i), .cfg_div_i(cfg_div_i), .start_i(start_i), .stop_i(stop_i),
    .man_valid_i(man_valid_i), .man_data_i(man_data_i), .man_ready_o(man_ready_o),
    .dac_data_o(dac_data_o), .dac_tvalid_o(dac_tvalid_o), .busy_o(busy_o), .dir_o(dir_o),
    .cfg_err_o(cfg_err_o), .period_cnt_o(period_cnt_o), .trig_o(trig_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: one full period of codes is tabulated at start; emission k shows P[k % L].
  int P[$];
  int L, imax;
  bit m_ok = 1'b0, m_run = 1'b0, m_err = 1'b0, m_tv = 1'b0, m_trig = 1'b0, m_dir = 1'b0;
  int m_data = 0, m_cnt = 0, m_e = 0, m_k = 0, m_div = 0;

  function automatic void build(input int mn, input int mx, input int st);
    int v;
    P.delete();
    v = mn;
    P.push_back(v);
    forever begin
      v += st;
      if (v >= mx) begin P.push_back(mx); break; end
      P.push_back(v);
    end
    imax = P.size() - 1;
    v = mx;
    while (!(v < mn + st)) begin
      v -= st;
      P.push_back(v);
    end
    L = P.size();
  endfunction

  function automatic void emit(input int k);
    int j;
    j = k % L;
    m_data = P[j];
    m_cnt  = (k / L) % (1 << CW);
    m_dir  = (j < imax);
    m_tv   = 1'b1;
    m_trig = TRIG_EN && (j == 0);
  endfunction

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    m_tv   = 1'b0;
    m_trig = 1'b0;
    if (rst_i) begin
      m_ok = 1'b1; m_run = 1'b0; m_err = 1'b0; m_dir = 1'b0;
      m_data = 'h2000; m_cnt = 0;
    end else if (!m_run) begin
      if (start_i && !stop_i) begin
        if (cfg_min_i < cfg_max_i && cfg_step_i != 0) begin
          build(int'(cfg_min_i), int'(cfg_max_i), int'(cfg_step_i));
          m_div = int'(cfg_div_i);
          m_run = 1'b1; m_err = 1'b0; m_e = 0; m_k = 0;
          emit(0);
        end else begin
          m_err = 1'b1;
        end
      end else if (man_valid_i && !start_i) begin
        m_data = int'(man_data_i);
        m_tv   = 1'b1;
      end
    end else if (stop_i) begin
      m_run = 1'b0;
      m_dir = 1'b0;
    end else begin
      m_e++;
      if (m_e % (m_div + 1) == 0) begin
        m_k++;
        emit(m_k);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("dac_data", dac_data_o, m_data);
      chk("tvalid", dac_tvalid_o, m_tv);
      chk("busy", busy_o, m_run);
      chk("dir", dir_o, m_dir);
      chk("cfg_err", cfg_err_o, m_err);
      chk("period_cnt", period_cnt_o, m_cnt);
      chk("trig", trig_o, m_trig);
      chk("man_ready", man_ready_o, (!m_run && !start_i));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int mn, input int mx, input int st, input int dv);
    cfg_min_i  = DW'(mn);
    cfg_max_i  = DW'(mx);
    cfg_step_i = DW'(st);
    cfg_div_i  = VW'(dv);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
  endtask

  task automatic wait_emit(output logic [DW-1:0] code, output logic trg,
                           output logic [CW-1:0] cnt, output int stamp);
    bit got;
    got = 1'b0;
    code = '0; trg = 1'b0; cnt = '0; stamp = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (dac_tvalid_o) begin
        got = 1'b1; code = dac_data_o; trg = trig_o; cnt = period_cnt_o; stamp = cyc_cnt;
      end
    end
    if (!got) chk("emit_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    logic [DW-1:0] code;
    logic          trg;
    logic [CW-1:0] cnt;
    int            stamp, prev;
    int            ntrig;
    logic [DW-1:0] basic_exp [9];
    logic [DW-1:0] ex2_exp [7];
    bit            found;
    int            mn, mx, st;

    basic_exp = '{14'h1000, 14'h1004, 14'h1008, 14'h100C, 14'h1010,
                  14'h100C, 14'h1008, 14'h1004, 14'h1000};
    ex2_exp   = '{14'h0, 14'h4, 14'h8, 14'hA, 14'h6, 14'h2, 14'h0};

    // Reset
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_dac", dac_data_o, 32'h2000);
    chk("rst_flags", {dac_tvalid_o, busy_o, dir_o, cfg_err_o, trig_o}, 32'd0);
    chk("rst_cnt", period_cnt_o, 32'd0);
    chk("rst_man_ready", man_ready_o, 32'd1);
    #1;

    // Basic sweep over two periods
    set_cfg('h1000, 'h1010, 4, 0);
    pulse_start();
    ntrig = 0;
    for (int i = 0; i < 19; i++) begin
      wait_emit(code, trg, cnt, stamp);
      if (i < 9) chk($sformatf("basic_code%0d", i), code, basic_exp[i]);
      if (i > 0) chk("basic_gap", stamp - prev, 32'd1);
      if (i == 9) chk("basic_cnt_after_turn", cnt, 32'd1);
      if (trg) begin
        ntrig++;
        chk("trig_code", code, 32'h1000);
      end
      prev = stamp;
    end
    chk("trig_count", ntrig, TRIG_EN ? 32'd3 : 32'd0);
    pulse_stop();

    // Non-aligned step with divider
    set_cfg(0, 'hA, 4, 2);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      wait_emit(code, trg, cnt, stamp);
      chk($sformatf("ex2_code%0d", i), code, ex2_exp[i]);
      if (i > 0) chk("ex2_gap", stamp - prev, 32'd3);
      prev = stamp;
    end
    pulse_stop();

    // Bad config then valid start
    set_cfg('h2000, 'h2000, 4, 0);
    pulse_start();
    @(negedge clk);
    chk("bad_err", cfg_err_o, 32'd1);
    chk("bad_busy", busy_o, 32'd0);
    chk("bad_tvalid", dac_tvalid_o, 32'd0);
    #1;
    set_cfg('h1000, 'h1010, 4, 0);
    pulse_start();
    @(negedge clk);
    chk("good_err", cfg_err_o, 32'd0);
    chk("good_tvalid", dac_tvalid_o, 32'd1);
    #1;

    // Manual request stalls during sweep, accepted after stop
    man_valid_i = 1'b1;
    man_data_i  = 14'h3FFF;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("arb_stall_ready", man_ready_o, 32'd0);
    end
    pulse_stop();
    cyc();
    @(negedge clk);
    chk("arb_man_data", dac_data_o, 32'h3FFF);
    chk("arb_man_tvalid", dac_tvalid_o, 32'd1);
    #1;
    man_valid_i = 1'b0;
    cyc();

    // Start and manual request together: start wins
    man_valid_i = 1'b1;
    man_data_i  = 14'h0123;
    start_i     = 1'b1;
    @(negedge clk);
    chk("arb_start_ready", man_ready_o, 32'd0);
    #1;
    cyc();
    start_i     = 1'b0;
    man_valid_i = 1'b0;
    @(negedge clk);
    chk("arb_start_busy", busy_o, 32'd1);
    chk("arb_start_data", dac_data_o, 32'h1000);
    #1;

    // Reset while ramping down
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (busy_o && !dir_o) found = 1'b1;
    end
    chk("reach_down", found, 32'd1);
    #1;
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_dac", dac_data_o, 32'h2000);
    chk("midrst_flags", {dac_tvalid_o, busy_o, dir_o, cfg_err_o, trig_o}, 32'd0);
    chk("midrst_cnt", period_cnt_o, 32'd0);
    #1;

    // Randomized traffic, checked by the per-cycle model
    for (int run = 0; run < 40; run++) begin
      for (int c = 0; c < 120; c++) begin
        if (c == 0 || $urandom_range(0, 9) == 0) begin
          mn = $urandom_range(0, (1 << DW) - 1);
          if ($urandom_range(0, 3) == 0) mx = $urandom_range(0, (1 << DW) - 1);
          else mx = mn + $urandom_range(0, 40);
          if (mx > (1 << DW) - 1) mx = (1 << DW) - 1;
          st = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 12);
          if ($urandom_range(0, 7) == 0) st = $urandom_range(1, (1 << DW) - 1);
          set_cfg(mn, mx, st, $urandom_range(0, 3));
        end
        start_i     = ($urandom_range(0, 14) == 0);
        stop_i      = ($urandom_range(0, 39) == 0);
        man_valid_i = ($urandom_range(0, 5) == 0);
        man_data_i  = DW'($urandom);
        rst_i       = ($urandom_range(0, 299) == 0);
        cyc();
      end
    end
    start_i = 1'b0; stop_i = 1'b0; man_valid_i = 1'b0; rst_i = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
